// File: rtl/if_fetch_buf_if.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_buf_if
//  Description : Instruction bus bundle between the fetch stage (master) and
//                the instruction memory (slave): addr_ok/data_ok handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
interface if_fetch_buf_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;

    modport master (
        output inst_req,
        output inst_addr,
        input  inst_addr_ok,
        input  inst_data_ok,
        input  inst_rdata
    );

    modport slave (
        input  inst_req,
        input  inst_addr,
        output inst_addr_ok,
        output inst_data_ok,
        output inst_rdata
    );
endinterface
`default_nettype wire

// File: rtl/if_fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : if_fetch_buf
//  Description : Instruction fetch stage. Issues word fetches on an
//                addr_ok/data_ok bus with up to BUF_DEPTH in flight, queues
//                returned instructions for ID, drops stale responses after
//                ex/ertn/branch redirects and raises ADEF on a misaligned PC.
//                Optional macro IF_PERF_CNT_EN adds fetch/cancel counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_buf #(
    parameter logic [31:0] RESET_PC  = 32'h1c00_0000,
    parameter int unsigned BUF_DEPTH = 4
) (
    input  wire logic        clk,
    input  wire logic        rst,
    input  wire logic        ex_flush,
    input  wire logic [31:0] ex_entry,
    input  wire logic        ertn_flush,
    input  wire logic [31:0] ertn_entry,
    input  wire logic        br_taken,
    input  wire logic [31:0] br_target,
    if_fetch_buf_if.master   bus,
    output logic             out_valid,
    input  wire logic        out_ready,
    output logic [31:0]      pc_out,
    output logic [31:0]      inst_out,
    output logic             has_exception_out,
    output logic [5:0]       ecode_out,
`ifdef IF_PERF_CNT_EN
    output logic [31:0]      perf_fetch_cnt,
    output logic [31:0]      perf_cancel_cnt,
`endif
    output logic [8:0]       esubcode_out
);

    localparam int unsigned c_cnt_w      = $clog2(BUF_DEPTH + 1);
    localparam int unsigned c_ptr_w      = $clog2(BUF_DEPTH);
    localparam logic [5:0]  c_ecode_adef = 6'h08;

    logic [31:0]        fetch_pc_q, fetch_pc_d;
    logic [c_cnt_w-1:0] inflight_q, inflight_d;
    logic [c_cnt_w-1:0] cancel_q,   cancel_d;
    logic               halted_q,   halted_d;
    logic               run_q;
    logic [31:0]        pend_pc_q [BUF_DEPTH];
    logic [31:0]        pend_pc_d [BUF_DEPTH];
    logic [c_ptr_w-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
    logic [31:0]        fifo_pc_q   [BUF_DEPTH];
    logic [31:0]        fifo_pc_d   [BUF_DEPTH];
    logic [31:0]        fifo_inst_q [BUF_DEPTH];
    logic [31:0]        fifo_inst_d [BUF_DEPTH];
    logic               fifo_exc_q  [BUF_DEPTH];
    logic               fifo_exc_d  [BUF_DEPTH];
    logic [c_ptr_w-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
    logic [c_cnt_w-1:0] fifo_cnt_q, fifo_cnt_d;

    logic               w_redirect;
    logic [31:0]        w_target;
    logic [c_cnt_w:0]   w_used;
    logic               w_aligned;
    logic               w_req;
    logic               w_accept;
    logic               w_resp;
    logic               w_drop;
    logic               w_push_resp;
    logic               w_push_adef;
    logic               w_push;
    logic               w_pop;
    logic               w_out_valid;
    logic [31:0]        w_push_pc;
    logic [31:0]        w_push_inst;

    assign w_redirect = ex_flush | ertn_flush | br_taken;

    // Redirect target: exception beats ertn beats branch.
    always_comb begin
        w_target = br_target;
        if (ex_flush) begin
            w_target = ex_entry;
        end else if (ertn_flush) begin
            w_target = ertn_entry;
        end
    end

    // Credits cover both live requests and buffered entries, so the FIFO
    // always has room for every response that is not being cancelled.
    assign w_used      = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};
    assign w_aligned   = (fetch_pc_q[1:0] == 2'b00);
    assign w_req       = run_q && !w_redirect && !halted_q && w_aligned &&
                         (w_used < (c_cnt_w + 1)'(BUF_DEPTH));
    assign w_accept    = w_req && bus.inst_addr_ok;
    assign w_resp      = bus.inst_data_ok;
    assign w_drop      = w_resp && (cancel_q != '0);
    assign w_push_resp = w_resp && (cancel_q == '0) && !w_redirect;
    // ADEF is queued only once every live response ahead of it has landed.
    assign w_push_adef = run_q && !w_redirect && !halted_q && !w_aligned &&
                         (inflight_q == cancel_q) &&
                         (fifo_cnt_q != c_cnt_w'(BUF_DEPTH));
    assign w_push      = w_push_resp || w_push_adef;
    assign w_out_valid = (fifo_cnt_q != '0);
    assign w_pop       = w_out_valid && out_ready && !w_redirect;
    assign w_push_pc   = w_push_adef ? fetch_pc_q : pend_pc_q[pend_rd_q];
    assign w_push_inst = w_push_adef ? 32'h0 : bus.inst_rdata;

    // Next-state for PC, counters, pending-PC queue and entry FIFO.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        inflight_d  = inflight_q;
        cancel_d    = cancel_q;
        halted_d    = halted_q;
        pend_pc_d   = pend_pc_q;
        pend_wr_d   = pend_wr_q;
        pend_rd_d   = pend_rd_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;
        fifo_exc_d  = fifo_exc_q;
        fifo_wr_d   = fifo_wr_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_cnt_d  = fifo_cnt_q;

        if (w_redirect) begin
            fetch_pc_d = w_target;
        end else if (w_accept) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        if (w_accept && !w_resp) begin
            inflight_d = inflight_q + c_cnt_w'(1);
        end else if (!w_accept && w_resp) begin
            inflight_d = inflight_q - c_cnt_w'(1);
        end

        // On redirect every response still owed after this edge is stale.
        if (w_redirect) begin
            cancel_d = w_resp ? (inflight_q - c_cnt_w'(1)) : inflight_q;
        end else if (w_drop) begin
            cancel_d = cancel_q - c_cnt_w'(1);
        end

        // Pending PCs survive redirects: cancelled responses still pop them.
        if (w_accept) begin
            pend_pc_d[pend_wr_q] = fetch_pc_q;
            pend_wr_d            = pend_wr_q + c_ptr_w'(1);
        end
        if (w_resp) begin
            pend_rd_d = pend_rd_q + c_ptr_w'(1);
        end

        if (w_redirect) begin
            halted_d   = 1'b0;
            fifo_wr_d  = '0;
            fifo_rd_d  = '0;
            fifo_cnt_d = '0;
        end else begin
            if (w_push_adef) begin
                halted_d = 1'b1;
            end
            if (w_push) begin
                fifo_pc_d[fifo_wr_q]   = w_push_pc;
                fifo_inst_d[fifo_wr_q] = w_push_inst;
                fifo_exc_d[fifo_wr_q]  = w_push_adef;
                fifo_wr_d              = fifo_wr_q + c_ptr_w'(1);
            end
            if (w_pop) begin
                fifo_rd_d = fifo_rd_q + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                fifo_cnt_d = fifo_cnt_q + c_cnt_w'(1);
            end else if (!w_push && w_pop) begin
                fifo_cnt_d = fifo_cnt_q - c_cnt_w'(1);
            end
        end
    end

    // State registers; run_q holds off the first request until after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q  <= RESET_PC;
            inflight_q  <= '0;
            cancel_q    <= '0;
            halted_q    <= 1'b0;
            run_q       <= 1'b0;
            pend_pc_q   <= '{default: '0};
            pend_wr_q   <= '0;
            pend_rd_q   <= '0;
            fifo_pc_q   <= '{default: '0};
            fifo_inst_q <= '{default: '0};
            fifo_exc_q  <= '{default: 1'b0};
            fifo_wr_q   <= '0;
            fifo_rd_q   <= '0;
            fifo_cnt_q  <= '0;
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            inflight_q  <= inflight_d;
            cancel_q    <= cancel_d;
            halted_q    <= halted_d;
            run_q       <= 1'b1;
            pend_pc_q   <= pend_pc_d;
            pend_wr_q   <= pend_wr_d;
            pend_rd_q   <= pend_rd_d;
            fifo_pc_q   <= fifo_pc_d;
            fifo_inst_q <= fifo_inst_d;
            fifo_exc_q  <= fifo_exc_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_cnt_q  <= fifo_cnt_d;
        end
    end

    // Outputs read zero whenever their qualifying valid is low.
    assign bus.inst_req      = w_req;
    assign bus.inst_addr     = w_req ? {fetch_pc_q[31:2], 2'b00} : 32'h0;
    assign out_valid         = w_out_valid;
    assign pc_out            = w_out_valid ? fifo_pc_q[fifo_rd_q]   : 32'h0;
    assign inst_out          = w_out_valid ? fifo_inst_q[fifo_rd_q] : 32'h0;
    assign has_exception_out = w_out_valid && fifo_exc_q[fifo_rd_q];
    assign ecode_out         = has_exception_out ? c_ecode_adef : 6'h0;
    assign esubcode_out      = 9'h0;

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_q,  perf_fetch_d;
    logic [31:0] perf_cancel_q, perf_cancel_d;

    // Count buffered instructions and every response that was thrown away.
    always_comb begin
        perf_fetch_d  = perf_fetch_q  + {31'h0, w_push_resp};
        perf_cancel_d = perf_cancel_q + {31'h0, (w_resp && !w_push_resp)};
    end

    // Free-running wrapping performance counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_fetch_q  <= '0;
            perf_cancel_q <= '0;
        end else begin
            perf_fetch_q  <= perf_fetch_d;
            perf_cancel_q <= perf_cancel_d;
        end
    end

    assign perf_fetch_cnt  = perf_fetch_q;
    assign perf_cancel_cnt = perf_cancel_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_buf.sv
`default_nettype none
// ============================================================================
//  Module      : tb_if_fetch_buf
//  Description : Self-checking bench for if_fetch_buf. A bus responder answers
//                accepted fetches (optionally holding responses), a monitor
//                compares each ID handshake against an expected-entry queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_buf;

    localparam logic [31:0] c_key = 32'hdead_beef;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        exc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_flush, ertn_flush, br_taken;
    logic [31:0] ex_entry, ertn_entry, br_target;
    logic        out_valid, out_ready, has_exception_out;
    logic [31:0] pc_out, inst_out;
    logic [5:0]  ecode_out;
    logic [8:0]  esubcode_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_cancel_cnt;
`endif

    exp_t        exp_q[$];
    logic [31:0] rq[$];
    logic [31:0] got_addr[$];
    int          budget = 0;
    bit          hold = 1'b0;
    int          n_checks = 0;
    int          n_pass = 0;

    if_fetch_buf_if bus();

    if_fetch_buf dut (
        .clk               (clk),
        .rst               (rst),
        .ex_flush          (ex_flush),
        .ex_entry          (ex_entry),
        .ertn_flush        (ertn_flush),
        .ertn_entry        (ertn_entry),
        .br_taken          (br_taken),
        .br_target         (br_target),
        .bus               (bus),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .pc_out            (pc_out),
        .inst_out          (inst_out),
        .has_exception_out (has_exception_out),
        .ecode_out         (ecode_out),
`ifdef IF_PERF_CNT_EN
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_cancel_cnt   (perf_cancel_cnt),
`endif
        .esubcode_out      (esubcode_out)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, got, exp);
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic exc);
        exp_t e;
        e.pc   = pc;
        e.inst = exc ? 32'h0 : (pc ^ c_key);
        e.exc  = exc;
        exp_q.push_back(e);
    endtask

    task automatic wait_idle(input string name, input int max);
        int k = 0;
        while ((exp_q.size() != 0 || budget != 0 || rq.size() != 0) && k < max) begin
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k < max) n_pass++;
        else $display("FAIL %s: timeout with %0d outputs outstanding, required 0", name, exp_q.size());
    endtask

    task automatic wait_addrs(input string name, input int n, input int max);
        int k = 0;
        while (got_addr.size() < n && k < max) begin
            @(negedge clk);
            #4;
            k++;
        end
        check32(name, 32'(got_addr.size()), 32'(n));
    endtask

    task automatic check_seq(input string name, input logic [31:0] base, input int n);
        check32({name, "_count"}, 32'(got_addr.size()), 32'(n));
        for (int i = 0; i < n && i < got_addr.size(); i++) begin
            check32(name, got_addr[i], base + 32'(4 * i));
        end
    endtask

    // Bus responder: accepts while budget lasts, answers in order next cycle
    // unless hold is set.
    initial begin
        bus.inst_addr_ok = 1'b0;
        bus.inst_data_ok = 1'b0;
        bus.inst_rdata   = 32'h0;
        forever begin
            @(negedge clk);
            #1;
            if (!rst) begin
                rq.delete();
                bus.inst_data_ok = 1'b0;
                bus.inst_addr_ok = 1'b0;
                bus.inst_rdata   = 32'h0;
            end else begin
                if (!hold && rq.size() > 0) begin
                    bus.inst_data_ok = 1'b1;
                    bus.inst_rdata   = rq.pop_front();
                end else begin
                    bus.inst_data_ok = 1'b0;
                    bus.inst_rdata   = 32'h0;
                end
                bus.inst_addr_ok = (budget > 0);
                #1;
                if (bus.inst_req && bus.inst_addr_ok) begin
                    budget--;
                    rq.push_back(bus.inst_addr ^ c_key);
                    got_addr.push_back(bus.inst_addr);
                end
            end
        end
    end

    // Output monitor: every accepted ID handshake must match the next entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (rst && out_valid && out_ready && !(ex_flush || ertn_flush || br_taken)) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_out: got pc %h, required no output", pc_out);
                end else begin
                    e = exp_q.pop_front();
                    check32("out_pc",    pc_out,   e.pc);
                    check32("out_inst",  inst_out, e.inst);
                    check32("out_exc",   {31'h0, has_exception_out}, {31'h0, e.exc});
                    check32("out_ecode", {26'h0, ecode_out}, e.exc ? 32'h8 : 32'h0);
                    check32("out_esub",  {23'h0, esubcode_out}, 32'h0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // Directed stimulus.
    initial begin
        int acc_k, val_k;
        rst = 1'b0; ex_flush = 1'b0; ertn_flush = 1'b0; br_taken = 1'b0;
        ex_entry = 32'h0; ertn_entry = 32'h0; br_target = 32'h0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check32("rst_inst_req",  {31'h0, bus.inst_req}, 32'h0);
        check32("rst_inst_addr", bus.inst_addr, 32'h0);
        check32("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check32("rst_pc_out",    pc_out, 32'h0);

        // Sequential fetch after reset, latency accept->out_valid of 2.
        @(negedge clk);
        rst = 1'b1; out_ready = 1'b1; budget = 3;
        push_exp(32'h1c00_0000, 1'b0);
        push_exp(32'h1c00_0004, 1'b0);
        push_exp(32'h1c00_0008, 1'b0);
        acc_k = -1; val_k = -1;
        for (int k = 0; k < 20; k++) begin
            if (k > 0) @(negedge clk);
            #4;
            if (acc_k < 0 && got_addr.size() > 0) acc_k = k;
            if (val_k < 0 && out_valid) val_k = k;
        end
        check32("latency", 32'(val_k - acc_k), 32'd2);
        wait_idle("t1_drain", 30);
        check_seq("t1_addr", 32'h1c00_0000, 3);
        got_addr.delete();

        // Backpressure: exactly BUF_DEPTH accepts, then resume in order.
        @(negedge clk);
        out_ready = 1'b0; budget = 10;
        repeat (10) @(negedge clk);
        #4;
        check32("bp_accepts",   32'(got_addr.size()), 32'd4);
        check32("bp_inst_req",  {31'h0, bus.inst_req}, 32'h0);
        check32("bp_out_valid", {31'h0, out_valid}, 32'h1);
        check32("bp_head_pc",   pc_out, 32'h1c00_000c);
        for (int i = 0; i < 10; i++) push_exp(32'h1c00_000c + 32'(4 * i), 1'b0);
        @(negedge clk);
        out_ready = 1'b1;
        wait_idle("t2_drain", 60);
        check_seq("t2_addr", 32'h1c00_000c, 10);
        got_addr.delete();

        // Branch with three requests in flight: stale data dropped.
        hold = 1'b1; budget = 3;
        wait_addrs("t3_inflight", 3, 20);
        @(negedge clk);
        br_taken = 1'b1; br_target = 32'h1c00_0100; budget = 2;
        push_exp(32'h1c00_0100, 1'b0);
        push_exp(32'h1c00_0104, 1'b0);
        @(negedge clk);
        br_taken = 1'b0; hold = 1'b0;
        wait_idle("t3_drain", 40);
        check32("t3_addr_count", 32'(got_addr.size()), 32'd5);
        if (got_addr.size() == 5) begin
            check32("t3_addr_old", got_addr[2], 32'h1c00_003c);
            check32("t3_addr_new", got_addr[3], 32'h1c00_0100);
            check32("t3_addr_new", got_addr[4], 32'h1c00_0104);
        end
        got_addr.delete();

        // Exception beats branch in the same cycle.
        @(negedge clk);
        ex_flush = 1'b1; ex_entry = 32'h1c00_8000;
        br_taken = 1'b1; br_target = 32'h1c00_0200; budget = 2;
        push_exp(32'h1c00_8000, 1'b0);
        push_exp(32'h1c00_8004, 1'b0);
        @(negedge clk);
        ex_flush = 1'b0; br_taken = 1'b0;
        wait_idle("t4_drain", 40);
        check_seq("t4_addr", 32'h1c00_8000, 2);
        got_addr.delete();

        // Misaligned ertn target (ertn beats branch): ADEF entry, then halt.
        @(negedge clk);
        ertn_flush = 1'b1; ertn_entry = 32'h1c00_0102;
        br_taken = 1'b1; br_target = 32'h1c00_0400; budget = 2;
        push_exp(32'h1c00_0102, 1'b1);
        @(negedge clk);
        ertn_flush = 1'b0; br_taken = 1'b0;
        repeat (8) @(negedge clk);
        #4;
        check32("adef_no_fetch", 32'(got_addr.size()), 32'd0);
        check32("adef_inst_req", {31'h0, bus.inst_req}, 32'h0);
        check32("adef_popped",   32'(exp_q.size()), 32'd0);
        @(negedge clk);
        br_taken = 1'b1; br_target = 32'h1c00_0300; budget = 0;
        @(negedge clk);
        br_taken = 1'b0;

        // Asynchronous reset with one buffered entry and two in flight.
        out_ready = 1'b0; budget = 1;
        wait_addrs("t6_first", 1, 20);
        hold = 1'b1; budget = 2;
        wait_addrs("t6_inflight", 3, 20);
        check32("t6_pre_valid", {31'h0, out_valid}, 32'h1);
        @(negedge clk);
        #3;
        rst = 1'b0;
        #1;
        check32("t6_async_valid", {31'h0, out_valid}, 32'h0);
        check32("t6_async_req",   {31'h0, bus.inst_req}, 32'h0);
        @(negedge clk);
        hold = 1'b0; budget = 0;
        exp_q.delete();
        @(negedge clk);
        got_addr.delete();
        rst = 1'b1; out_ready = 1'b1; budget = 1;
        push_exp(32'h1c00_0000, 1'b0);
        wait_idle("t6_drain", 30);
        check_seq("t6_addr", 32'h1c00_0000, 1);

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/if_fetch_buf.md
Name: if_fetch_buf

Overview:
- Next-generation instruction fetch stage for the LoongArch pipeline.
- Drives a request/response (addr_ok/data_ok) instruction bus with up to BUF_DEPTH requests in flight.
- Buffers returned instructions in a FIFO in front of ID.
- Handles exception, ertn and branch redirects by discarding stale in-flight responses, and raises ADEF for a misaligned PC.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.
- BUF_DEPTH, 4, instruction FIFO depth and outstanding-request limit; power of 2, at least 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- ex_flush  in  1  exception redirect.
- ex_entry  in  32  exception target.
- ertn_flush  in  1  ertn redirect.
- ertn_entry  in  32  ertn target.
- br_taken  in  1  branch redirect.
- br_target  in  32  branch target.
- inst_req  out  1  bus request.
- inst_addr  out  32  request address, word aligned.
- inst_addr_ok  in  1  address accepted.
- inst_data_ok  in  1  response valid.
- inst_rdata  in  32  response data.
- out_valid  out  1  FIFO head valid to ID.
- out_ready  in  1  ID accepts.
- pc_out  out  32  head PC.
- inst_out  out  32  head instruction.
- has_exception_out  out  1  head carries ADEF.
- ecode_out  out  6  head ecode.
- esubcode_out  out  9  head esubcode.

Behaviour:
- Reset values (rst low, asynchronous):
  - fetch_pc = RESET_PC.
  - FIFO empty; inflight = 0; cancel = 0; halted = 0.
  - All outputs 0; out_valid = 0.
  - First inst_req may assert in the first cycle after rst rises.
- State:
  - fetch_pc register.
  - inflight counter: requests accepted but not yet answered.
  - cancel counter: responses to drop.
  - pending-PC queue: BUF_DEPTH entries, PC per accepted request.
  - Entry FIFO: BUF_DEPTH entries of {pc, inst, exc}.
  - halted flag.
  - Counter widths are $clog2(BUF_DEPTH+1).
- Redirect priority: ex_flush > ertn_flush > br_taken. redirect = any of the three.
- Request issue:
  - inst_req = !redirect && !halted && fetch_pc[1:0]==0 && (inflight + fifo_count) < BUF_DEPTH.
  - inst_addr = {fetch_pc[31:2], 2'b00}.
  - On inst_req && inst_addr_ok: push fetch_pc to the pending queue, fetch_pc += 4, inflight += 1.
- Response:
  - On inst_data_ok: pop the pending queue; inflight -= 1.
  - If cancel > 0: cancel -= 1 and discard the data.
  - Otherwise push {pc, inst_rdata, exc=0} into the FIFO.
  - Accept and response in the same cycle: net inflight change is 0.
- Credit rule (inflight + fifo_count < BUF_DEPTH) guarantees the FIFO never overflows.
  - A response arriving while the FIFO is full is a protocol violation; the block does not need to handle it.
- ADEF:
  - When fetch_pc[1:0] != 0, no bus request is made.
  - Once inflight == cancel (all live responses returned), push {fetch_pc, 32'h0, exc=1} and set halted.
  - halted clears only on redirect.
  - ADEF entry outputs: ecode_out = 6'h08, esubcode_out = 9'h0. Non-exception entries output ecode 0, esubcode 0.
- Redirect cycle:
  - inst_req forced 0.
  - fetch_pc <= selected target; FIFO cleared (a simultaneous pop is ignored); halted <= 0.
  - cancel <= total responses still owed after this edge: inflight minus a data_ok this cycle. All of them are dropped.
  - The next fetch issues the cycle after the redirect.
  - Redirect to a misaligned target produces an ADEF entry as above.
- Output:
  - out_valid = FIFO non-empty; pc_out, inst_out and exception fields show the head entry.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle are both performed.
- Latency: address accepted in cycle T, data_ok in T+1, out_valid in T+2.
  - Back-to-back throughput is 1 instruction per cycle when addr_ok and data_ok are held high.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs perf_fetch_cnt [31:0] and perf_cancel_cnt [31:0], reset to 0 and wrapping.
  - perf_fetch_cnt increments per FIFO push of a non-exception entry.
  - perf_cancel_cnt increments per discarded response.
- Without the macro: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Reset release, bus addr_ok=1 and data_ok one cycle after each accept, out_ready=1 -> inst_addr sequence 1c000000, 1c000004, 1c000008; first out_valid 2 cycles after the first accept with pc_out=1c000000.
- out_ready=0 with fast bus -> exactly BUF_DEPTH=4 accepts, then inst_req=0; raise out_ready -> heads 1c000000..1c00000c in order, fetching resumes.
- 3 requests in flight, br_taken to 1c000100 -> 3 responses dropped, next inst_addr=1c000100, first out pc_out=1c000100.
- ex_flush and br_taken in the same cycle (ex_entry=1c008000) -> fetch resumes at 1c008000.
- ertn_entry=1c000102 -> no bus request; one entry with has_exception_out=1, ecode_out=6'h08, pc_out=1c000102; inst_req stays 0 until the next redirect.
- rst driven low mid-transfer (2 in flight) -> out_valid=0 and inst_req=0 immediately, without waiting for a clock edge; after release, first inst_addr=1c000000.
